instr_encoder_loader: RTL and testbench

//  Encoder counterpart of the control-unit decoder: turns abstract ops (kind, rd, rs1, rs2, imm)

---
 rtl/instr_encoder_loader_if.sv | 38 +++
 rtl/instr_encoder_loader.sv | 167 ++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Bundles the op-input handshake, the instruction-memory write port and the
// status flags of instr_encoder_loader into one interface.
//   in_valid/in_ready        op handshake (producer -> encoder)
//   in_kind/rd/rs1/rs2/imm   abstract op fields
//   flush                    end of program, drain and pulse done
//   mem_we/mem_ready         write handshake (encoder -> instruction memory)
//   mem_addr/mem_wdata       write word address and encoded instruction
//   done/err/wrapped         drain-complete pulse, sticky illegal-op, sticky address wrap
// The slave modport is the encoder's view; master is the producer/memory side.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [11:0]       in_imm;
    logic              flush;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              err;
    logic              wrapped;

    modport slave (
        input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, flush, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, done, err, wrapped
    );

    modport master (
        output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, flush, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, done, err, wrapped
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes abstract ops (ADD/SUB/AND/OR/SLT/ADDI) into RV32I R/I-type words,
// buffers them in a DEPTH-entry FIFO and writes them to consecutive
// instruction-memory word addresses starting at BASE_ADDR.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   instr_encoder_loader_if.slave: op handshake, memory write port,
//         done pulse, sticky err and wrapped flags
// A flush stops accepting ops, lets the FIFO drain, pulses done for one cycle
// and rewinds the write address to BASE_ADDR.
module instr_encoder_loader #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_encoder_loader_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [6:0] R_OPCODE = 7'b0110011;
    localparam logic [6:0] I_OPCODE = 7'b0010011;

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       fifo_q [DEPTH];
    logic [31:0]       fifo_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              wrapped_q, wrapped_d;

    logic        in_ready;
    logic        done;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        kind_legal;
    logic        is_imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] enc_word;

    // Combinational encoder: R-type ops differ only in funct3/funct7, ADDI
    // uses the I-type layout. Kinds 110/111 are flagged illegal.
    always_comb begin
        f3         = 3'b000;
        f7         = 7'b0000000;
        is_imm     = 1'b0;
        kind_legal = 1'b1;
        case (bus.in_kind)
            3'b000:  f3 = 3'b000;
            3'b001:  f7 = 7'b0100000;
            3'b010:  f3 = 3'b111;
            3'b011:  f3 = 3'b110;
            3'b101:  f3 = 3'b010;
            3'b100:  is_imm = 1'b1;
            default: kind_legal = 1'b0;
        endcase
        enc_word = is_imm ? {bus.in_imm, bus.in_rs1, 3'b000, bus.in_rd, I_OPCODE}
                          : {f7, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, R_OPCODE};
    end

    // FSM output logic. A full FIFO refuses ops even if a pop happens the
    // same cycle, so in_ready never depends on mem_ready.
    always_comb begin
        in_ready = (state_q == ST_ACCEPT) && !bus.flush && (count_q < DEPTH_C);
        done     = (state_q == ST_DONE);
    end

    assign fifo_empty = (count_q == '0);
    assign accept     = bus.in_valid & in_ready;
    // An illegal op completes its handshake but never enters the FIFO.
    assign push       = accept & kind_legal;
    assign pop        = ~fifo_empty & bus.mem_ready;

    // FSM next-state logic. Flush only matters in ACCEPT; DRAIN leaves as
    // soon as the FIFO is empty after this cycle's pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCEPT: if (bus.flush) state_d = ST_DRAIN;
            ST_DRAIN:  if (count_d == '0) state_d = ST_DONE;
            ST_DONE:   state_d = ST_ACCEPT;
            default:   state_d = ST_ACCEPT;
        endcase
    end

    // FIFO, write address and sticky flag next-state logic.
    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        err_d     = err_q | (accept & ~kind_legal);
        wrapped_d = wrapped_q;

        if (push) begin
            fifo_d[wr_ptr_q] = enc_word;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        // DONE is only reached with an empty FIFO, so it never collides with a pop.
        if (state_q == ST_DONE) begin
            addr_d = BASE_ADDR;
        end else if (pop) begin
            addr_d = addr_q + ADDR_W'(1);
            if (addr_q == '1) begin
                wrapped_d = 1'b1;
            end
        end
    end

    // State register and datapath flops; reset discards FIFO contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACCEPT;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.done      = done;
    assign bus.mem_we    = ~fifo_empty;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = fifo_empty ? 32'h0 : fifo_q[rd_ptr_q];
    assign bus.err       = err_q;
    assign bus.wrapped   = wrapped_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: directed scenarios plus a randomized
// run against a queue-based reference model. A second instance with a
// 2-bit address exercises address wrap-around and mid-stream reset.
module tb_instr_encoder_loader;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_encoder_loader_if #(.ADDR_W(8)) ifm ();
    instr_encoder_loader_if #(.ADDR_W(2)) ifs ();

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(8'd0)) dut (
        .clk(clk), .rst(rst), .bus(ifm)
    );

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(2), .BASE_ADDR(2'd0)) dut_small (
        .clk(clk), .rst(rst), .bus(ifs)
    );

    // Reference encoding built from the RV32I field layout.
    function automatic logic [31:0] encode(input int kind, input int rd, input int rs1,
                                           input int rs2, input int imm);
        logic [31:0] f3;
        logic [31:0] f7;
        f3 = 0;
        f7 = 0;
        if (kind == 4) begin
            return (32'(imm) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
        end
        case (kind)
            1:       f7 = 32'h20;
            2:       f3 = 7;
            3:       f3 = 6;
            5:       f3 = 2;
            default: f3 = 0;
        endcase
        return (f7 << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (f3 << 12)
             | (32'(rd) << 7) | 32'h33;
    endfunction

    function automatic bit legal(input int kind);
        return kind inside {0, 1, 2, 3, 4, 5};
    endfunction

    task automatic set_op(input bit v, input int k, input int rd, input int rs1,
                          input int rs2, input int imm);
        ifm.in_valid = v;
        ifm.in_kind  = 3'(k);
        ifm.in_rd    = 5'(rd);
        ifm.in_rs1   = 5'(rs1);
        ifm.in_rs2   = 5'(rs2);
        ifm.in_imm   = 12'(imm);
    endtask

    task automatic set_op_small(input bit v, input int k, input int rd, input int rs1,
                                input int rs2, input int imm);
        ifs.in_valid = v;
        ifs.in_kind  = 3'(k);
        ifs.in_rd    = 5'(rd);
        ifs.in_rs1   = 5'(rs1);
        ifs.in_rs2   = 5'(rs2);
        ifs.in_imm   = 12'(imm);
    endtask

    task automatic idle_inputs();
        set_op(0, 0, 0, 0, 0, 0);
        set_op_small(0, 0, 0, 0, 0, 0);
        ifm.flush     = 1'b0;
        ifm.mem_ready = 1'b0;
        ifs.flush     = 1'b0;
        ifs.mem_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] got, exp;
        idle_inputs();
        rst = 1'b1;
        #2;
        got = 64'({ifm.in_ready, ifm.mem_we, ifm.mem_addr, ifm.mem_wdata, ifm.done, ifm.err, ifm.wrapped});
        exp = 64'({1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL reset_values: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
        rst = 1'b0;
        mid();
        got = 64'({ifs.in_ready, ifs.mem_we, ifs.mem_addr, ifs.mem_wdata, ifs.done, ifs.err, ifs.wrapped});
        exp = 64'({1'b1, 1'b0, 2'h0, 32'h0, 1'b0, 1'b0, 1'b0});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL reset_small: got %h expected %h", got, exp);
        end
        checks++;
    endtask

    task automatic test_add();
        logic [63:0] got, exp;
        do_reset();
        ifm.mem_ready = 1'b1;
        set_op(1, 0, 3, 1, 2, 0);
        mid();
        got = 64'({ifm.in_ready, ifm.mem_we});
        exp = 64'({1'b1, 1'b0});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL add_accept: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
        set_op(0, 0, 0, 0, 0, 0);
        mid();
        got = 64'({ifm.mem_we, ifm.mem_addr, ifm.mem_wdata});
        exp = 64'({1'b1, 8'h00, 32'h002081B3});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL add_write: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
        mid();
        got = 64'({ifm.mem_we, ifm.mem_addr});
        exp = 64'({1'b0, 8'h01});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL add_after: got %h expected %h", got, exp);
        end
        checks++;
    endtask

    task automatic test_sub_addi();
        logic [63:0] got, exp;
        do_reset();
        ifm.mem_ready = 1'b1;
        set_op(1, 1, 5, 6, 7, 0);
        next_cycle();
        set_op(1, 4, 1, 0, 0, 12'hFFF);
        mid();
        got = 64'({ifm.mem_we, ifm.mem_addr, ifm.mem_wdata});
        exp = 64'({1'b1, 8'h00, 32'h407302B3});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL sub_write: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
        set_op(0, 0, 0, 0, 0, 0);
        mid();
        got = 64'({ifm.mem_we, ifm.mem_addr, ifm.mem_wdata});
        exp = 64'({1'b1, 8'h01, 32'hFFF00093});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL addi_write: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [63:0] got, exp;
        logic [31:0] w [5];
        int k [5] = '{0, 1, 2, 4, 5};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            w[i] = encode(k[i], 4 + 3 * i, 5 + 3 * i, 6 + 3 * i, 12'h123 + i);
        end
        for (int i = 0; i < 5; i++) begin
            set_op(1, k[i], 4 + 3 * i, 5 + 3 * i, 6 + 3 * i, 12'h123 + i);
            mid();
            got = 64'({ifm.in_ready, ifm.mem_we, ifm.mem_addr, ifm.mem_wdata});
            exp = (i == 0) ? 64'({1'b1, 1'b0, 8'h00, 32'h0})
                           : 64'({(i < 4), 1'b1, 8'h00, w[0]});
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL bp_fill[%0d]: got %h expected %h", i, got, exp);
            end
            checks++;
            next_cycle();
        end
        set_op(0, 0, 0, 0, 0, 0);
        mid();
        got = 64'({ifm.in_ready, ifm.mem_we, ifm.mem_addr, ifm.mem_wdata});
        exp = 64'({1'b0, 1'b1, 8'h00, w[0]});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL bp_hold: got %h expected %h", got, exp);
        end
        checks++;
        ifm.mem_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            got = 64'({ifm.mem_we, ifm.mem_addr, ifm.mem_wdata});
            exp = 64'({1'b1, 8'(j), w[j]});
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL bp_drain[%0d]: got %h expected %h", j, got, exp);
            end
            checks++;
            next_cycle();
            mid();
        end
        got = 64'({ifm.mem_we, ifm.mem_addr, ifm.in_ready});
        exp = 64'({1'b0, 8'h04, 1'b1});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL bp_empty: got %h expected %h", got, exp);
        end
        checks++;
    endtask

    task automatic test_illegal();
        logic [63:0] got, exp;
        do_reset();
        ifm.mem_ready = 1'b1;
        set_op(1, 6, 1, 2, 3, 0);
        mid();
        got = 64'({ifm.in_ready, ifm.err});
        exp = 64'({1'b1, 1'b0});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL illegal_accept: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
        set_op(1, 3, 1, 2, 3, 0);
        mid();
        got = 64'({ifm.mem_we, ifm.err});
        exp = 64'({1'b0, 1'b1});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL illegal_nopush: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
        set_op(0, 0, 0, 0, 0, 0);
        mid();
        got = 64'({ifm.mem_we, ifm.mem_addr, ifm.mem_wdata, ifm.err});
        exp = 64'({1'b1, 8'h00, 32'h003160B3, 1'b1});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL or_write: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
        mid();
        got = 64'({ifm.mem_we, ifm.mem_addr, ifm.err});
        exp = 64'({1'b0, 8'h01, 1'b1});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL err_sticky: got %h expected %h", got, exp);
        end
        checks++;
    endtask

    task automatic test_flush();
        logic [63:0] got, exp;
        logic [31:0] w0, w1, w2;
        w0 = encode(0, 1, 2, 3, 0);
        w1 = encode(2, 4, 5, 6, 0);
        w2 = encode(1, 2, 3, 4, 0);
        do_reset();
        set_op(1, 0, 1, 2, 3, 0);
        next_cycle();
        set_op(1, 2, 4, 5, 6, 0);
        next_cycle();
        set_op(1, 3, 7, 8, 9, 0);
        ifm.flush = 1'b1;
        mid();
        got = 64'({ifm.in_ready, ifm.done});
        exp = 64'({1'b0, 1'b0});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL flush_priority: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
        ifm.mem_ready = 1'b1;
        mid();
        got = 64'({ifm.in_ready, ifm.done, ifm.mem_we, ifm.mem_addr, ifm.mem_wdata});
        exp = 64'({1'b0, 1'b0, 1'b1, 8'h00, w0});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL drain_first: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
        mid();
        got = 64'({ifm.in_ready, ifm.done, ifm.mem_we, ifm.mem_addr, ifm.mem_wdata});
        exp = 64'({1'b0, 1'b0, 1'b1, 8'h01, w1});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL drain_second: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
        ifm.flush = 1'b0;
        set_op(0, 0, 0, 0, 0, 0);
        mid();
        got = 64'({ifm.in_ready, ifm.done, ifm.mem_we, ifm.mem_addr, ifm.mem_wdata});
        exp = 64'({1'b0, 1'b1, 1'b0, 8'h02, 32'h0});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL done_pulse: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
        mid();
        got = 64'({ifm.in_ready, ifm.done, ifm.mem_we, ifm.mem_addr});
        exp = 64'({1'b1, 1'b0, 1'b0, 8'h00});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL after_done: got %h expected %h", got, exp);
        end
        checks++;
        set_op(1, 1, 2, 3, 4, 0);
        next_cycle();
        set_op(0, 0, 0, 0, 0, 0);
        mid();
        got = 64'({ifm.mem_we, ifm.mem_addr, ifm.mem_wdata});
        exp = 64'({1'b1, 8'h00, w2});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL restart_addr: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
    endtask

    task automatic test_flush_empty();
        logic [63:0] got, exp;
        do_reset();
        ifm.flush = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mid();
            got = 64'({ifm.in_ready, ifm.done});
            exp = 64'({(c == 3), (c == 2)});
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL flush_empty[%0d]: got %h expected %h", c, got, exp);
            end
            checks++;
            next_cycle();
            ifm.flush = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [63:0] got, exp;
        logic [31:0] q [$];
        int  exp_addr;
        bit  exp_err, exp_wrapped, exp_ready, v, mr;
        int  k, rd, rs1, rs2, imm;
        exp_addr    = 0;
        exp_err     = 0;
        exp_wrapped = 0;
        do_reset();
        for (int cyc = 0; cyc < 700; cyc++) begin
            v   = ($urandom_range(0, 9) < 7);
            k   = (($urandom_range(0, 15)) == 0) ? 6 + $urandom_range(0, 1) : $urandom_range(0, 5);
            rd  = $urandom_range(0, 31);
            rs1 = $urandom_range(0, 31);
            rs2 = $urandom_range(0, 31);
            imm = $urandom_range(0, 4095);
            mr  = ($urandom_range(0, 9) < 6);
            set_op(v, k, rd, rs1, rs2, imm);
            ifm.mem_ready = mr;
            mid();
            exp_ready = (q.size() < DEPTH);
            got = 64'({ifm.in_ready, ifm.mem_we, ifm.mem_addr, ifm.mem_wdata, ifm.err, ifm.wrapped});
            exp = 64'({exp_ready, (q.size() > 0), 8'(exp_addr), (q.size() > 0) ? q[0] : 32'h0,
                       exp_err, exp_wrapped});
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL random_cycle[%0d]: got %h expected %h", cyc, got, exp);
            end
            checks++;
            if (q.size() > 0 && mr) begin
                void'(q.pop_front());
                if (exp_addr == 255) exp_wrapped = 1;
                exp_addr = (exp_addr + 1) % 256;
            end
            if (v && exp_ready) begin
                if (legal(k)) q.push_back(encode(k, rd, rs1, rs2, imm));
                else exp_err = 1;
            end
            next_cycle();
        end
        set_op(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_wrap_reset();
        logic [63:0] got, exp;
        logic [31:0] ws [5];
        do_reset();
        ifs.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ws[i] = encode(0, i + 1, i + 2, i + 3, 0);
        end
        for (int i = 0; i < 5; i++) begin
            set_op_small(1, 0, i + 1, i + 2, i + 3, 0);
            mid();
            got = 64'({ifs.mem_we, ifs.mem_addr, ifs.mem_wdata, ifs.wrapped});
            exp = (i == 0) ? 64'({1'b0, 2'd0, 32'h0, 1'b0})
                           : 64'({1'b1, 2'(i - 1), ws[i - 1], 1'b0});
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL wrap_write[%0d]: got %h expected %h", i, got, exp);
            end
            checks++;
            next_cycle();
        end
        set_op_small(1, 7, 0, 0, 0, 0);
        ifs.mem_ready = 1'b0;
        mid();
        got = 64'({ifs.mem_we, ifs.mem_addr, ifs.mem_wdata, ifs.wrapped});
        exp = 64'({1'b1, 2'd0, ws[4], 1'b1});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL wrap_fifth: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
        set_op_small(0, 0, 0, 0, 0, 0);
        mid();
        got = 64'({ifs.err, ifs.wrapped, ifs.mem_we});
        exp = 64'({1'b1, 1'b1, 1'b1});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL pre_reset_flags: got %h expected %h", got, exp);
        end
        checks++;
        rst = 1'b1;
        #1;
        got = 64'({ifs.mem_we, ifs.mem_addr, ifs.mem_wdata, ifs.err, ifs.wrapped, ifs.done, ifs.in_ready});
        exp = 64'({1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected %h", got, exp);
        end
        checks++;
        next_cycle();
        rst = 1'b0;
        ifs.mem_ready = 1'b1;
        mid();
        got = 64'({ifs.mem_we, ifs.mem_addr, ifs.err, ifs.wrapped});
        exp = 64'({1'b0, 2'd0, 1'b0, 1'b0});
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL fifo_discarded: got %h expected %h", got, exp);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_addi();
        test_backpressure();
        test_illegal();
        test_flush();
        test_flush_empty();
        test_random();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
